// File: rtl/bit_alloc_pool_pkg.sv
// Shared types and helpers for the bit allocation pool.
package bit_alloc_pool_pkg;

  // Largest pool the count helper has to cover.
  localparam int MAX_WIDTH = 256;
  localparam int MAX_CNTW  = 9;

  // Width of a lane rank; enough for up to four lanes.
  localparam int RANKW = 3;

  // Scan direction for the n-th set bit search.
  typedef enum logic {
    DIR_LOW  = 1'b0,
    DIR_HIGH = 1'b1
  } dir_e;

  // Population count over a zero-extended mask.
  function automatic logic [MAX_CNTW-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [MAX_CNTW-1:0] c;
    c = {MAX_CNTW{1'b0}};
    for (int i = 0; i < MAX_WIDTH; i++) begin
      c = c + {{(MAX_CNTW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bit_alloc_pool_find.sv
// Locates the rank-th set bit of a mask, scanning from the low or high end.
module bit_find_nth
  import bit_alloc_pool_pkg::*;
#(
  parameter int   WIDTH = 64,
  localparam int  IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mask,
  input  logic [RANKW-1:0] i_rank,
  input  dir_e             i_dir,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_found
);

  logic [RANKW-1:0] w_cnt;
  logic [IDXW-1:0]  w_pos;

  // Walk the mask in scan order, counting set bits until the requested rank is hit.
  always_comb begin
    w_cnt   = {RANKW{1'b0}};
    w_pos   = {IDXW{1'b0}};
    o_idx   = {IDXW{1'b0}};
    o_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_dir == DIR_HIGH) begin
        w_pos = IDXW'(WIDTH - 1 - i);
      end else begin
        w_pos = IDXW'(i);
      end
      if (i_mask[w_pos] && !o_found) begin
        if (w_cnt == i_rank) begin
          o_found = 1'b1;
          o_idx   = w_pos;
        end else begin
          w_cnt = w_cnt + {{(RANKW-1){1'b0}}, 1'b1};
        end
      end else begin
        w_cnt = w_cnt;
      end
    end
  end

endmodule

// File: rtl/bit_alloc_pool.sv
// Multi-lane free-index allocator: a free bitmap with compacted per-lane grants.
module bit_alloc_pool
  import bit_alloc_pool_pkg::*;
#(
  parameter int  WIDTH      = 64,
  parameter int  NGRANT     = 2,
  parameter int  HIGH_FIRST = 0,
  localparam int IDXW       = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NGRANT-1:0]      alloc_req,
  output logic [NGRANT-1:0]      alloc_gnt,
  output logic [NGRANT*IDXW-1:0] alloc_idx,
  input  logic [WIDTH-1:0]       free_mask,
  output logic [IDXW:0]          free_cnt,
  output logic                   empty,
  output logic                   err_dblfree
);

  localparam dir_e LANE_DIR = (HIGH_FIRST != 0) ? DIR_HIGH : DIR_LOW;

  logic [WIDTH-1:0]       r_pool;
  logic [IDXW:0]          r_free_cnt;
  logic [NGRANT-1:0]      r_gnt;
  logic [NGRANT*IDXW-1:0] r_idx;
  logic                   r_dblfree;

  logic [RANKW-1:0]       w_rank [NGRANT];
  logic [RANKW-1:0]       w_run;
  logic [IDXW-1:0]        w_lane_idx [NGRANT];
  logic [NGRANT-1:0]      w_lane_found;
  logic [NGRANT-1:0]      w_gnt;
  logic [NGRANT*IDXW-1:0] w_idx;
  logic [WIDTH-1:0]       w_gnt_bits;
  logic [WIDTH-1:0]       w_pool_nxt;
  logic [MAX_WIDTH-1:0]   w_pool_ext;
  logic [IDXW:0]          w_cnt_nxt;
  logic                   w_dblfree;

  // Compact requesting lanes: each lane's rank is the number of requesters below it.
  always_comb begin
    w_run = {RANKW{1'b0}};
    for (int i = 0; i < NGRANT; i++) begin
      w_rank[i] = w_run;
      w_run     = w_run + {{(RANKW-1){1'b0}}, alloc_req[i]};
    end
  end

  // One search per lane; only the registered pool is searched, so releases land a cycle later.
  for (genvar g = 0; g < NGRANT; g++) begin : g_lane
    bit_find_nth #(
      .WIDTH (WIDTH)
    ) u_find (
      .i_mask  (r_pool),
      .i_rank  (w_rank[g]),
      .i_dir   (LANE_DIR),
      .o_idx   (w_lane_idx[g]),
      .o_found (w_lane_found[g])
    );
  end

  // Turn lane search results into grants and the set of bits they consume.
  always_comb begin
    w_gnt      = {NGRANT{1'b0}};
    w_idx      = {(NGRANT*IDXW){1'b0}};
    w_gnt_bits = {WIDTH{1'b0}};
    for (int i = 0; i < NGRANT; i++) begin
      if (alloc_req[i] && w_lane_found[i]) begin
        w_gnt[i]                   = 1'b1;
        w_idx[i*IDXW +: IDXW]      = w_lane_idx[i];
        w_gnt_bits[w_lane_idx[i]]  = 1'b1;
      end else begin
        w_gnt[i] = 1'b0;
      end
    end
  end

  // Next pool value, its population count and the double-release flag.
  always_comb begin
    w_pool_nxt              = (r_pool & ~w_gnt_bits) | free_mask;
    w_dblfree               = |(free_mask & r_pool);
    w_pool_ext              = {MAX_WIDTH{1'b0}};
    w_pool_ext[WIDTH-1:0]   = w_pool_nxt;
    w_cnt_nxt               = (IDXW+1)'(popcount(w_pool_ext));
  end

  // Pool, count and output registers; reset discards in-flight grants and releases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pool     <= {WIDTH{1'b1}};
      r_free_cnt <= (IDXW+1)'(WIDTH);
      r_gnt      <= {NGRANT{1'b0}};
      r_idx      <= {(NGRANT*IDXW){1'b0}};
      r_dblfree  <= 1'b0;
    end else begin
      r_pool     <= w_pool_nxt;
      r_free_cnt <= w_cnt_nxt;
      r_gnt      <= w_gnt;
      r_idx      <= w_idx;
      r_dblfree  <= w_dblfree;
    end
  end

  assign alloc_gnt   = r_gnt;
  assign alloc_idx   = r_idx;
  assign free_cnt    = r_free_cnt;
  assign err_dblfree = r_dblfree;
  assign empty       = (r_free_cnt == {(IDXW+1){1'b0}});

endmodule

// File: tb/tb_bit_alloc_pool.sv
// Bench for bit_alloc_pool (WIDTH=8, NGRANT=2): low-first and high-first instances
// share stimulus and are compared every cycle against a queue-based model.
module tb_bit_alloc_pool;

  logic       clk;
  logic       rst_n;
  logic [1:0] alloc_req;
  logic [7:0] free_mask;

  logic [1:0] gnt_lo, gnt_hi;
  logic [5:0] idx_lo, idx_hi;
  logic [3:0] cnt_lo, cnt_hi;
  logic       empty_lo, empty_hi;
  logic       err_lo, err_hi;

  int n_checks = 0;
  int n_errors = 0;

  bit_alloc_pool #(.WIDTH(8), .NGRANT(2), .HIGH_FIRST(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(gnt_lo),
    .alloc_idx(idx_lo), .free_mask(free_mask), .free_cnt(cnt_lo),
    .empty(empty_lo), .err_dblfree(err_lo)
  );

  bit_alloc_pool #(.WIDTH(8), .NGRANT(2), .HIGH_FIRST(1)) u_hi (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(gnt_hi),
    .alloc_idx(idx_hi), .free_mask(free_mask), .free_cnt(cnt_hi),
    .empty(empty_hi), .err_dblfree(err_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_pool  [2];
  logic [1:0] exp_gnt [2];
  logic [5:0] exp_idx [2];
  logic [3:0] exp_cnt [2];
  logic       exp_err [2];
  logic       m_valid = 1'b0;
  int         q[$];
  int         k;
  logic [7:0] taken;

  // Model: list free indices in preference order, hand the k-th to the k-th requester.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_pool[d]  = 8'hFF;
        exp_gnt[d] = 2'b00;
        exp_idx[d] = 6'd0;
        exp_cnt[d] = 4'd8;
        exp_err[d] = 1'b0;
      end else begin
        q.delete();
        for (int n = 0; n < 8; n++) begin
          if (m_pool[d][(d == 0) ? n : 7 - n]) q.push_back((d == 0) ? n : 7 - n);
        end
        taken      = 8'h00;
        k          = 0;
        exp_gnt[d] = 2'b00;
        exp_idx[d] = 6'd0;
        for (int i = 0; i < 2; i++) begin
          if (alloc_req[i]) begin
            if (k < q.size()) begin
              exp_gnt[d][i]       = 1'b1;
              exp_idx[d][i*3 +: 3] = 3'(q[k]);
              taken[q[k]]         = 1'b1;
            end
            k++;
          end
        end
        exp_err[d] = |(free_mask & m_pool[d]);
        m_pool[d]  = (m_pool[d] & ~taken) | free_mask;
        exp_cnt[d] = 4'($countones(m_pool[d]));
      end
    end
    m_valid = 1'b1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt_lo",   32'(gnt_lo),   32'(exp_gnt[0]));
      chk("idx_lo",   32'(idx_lo),   32'(exp_idx[0]));
      chk("cnt_lo",   32'(cnt_lo),   32'(exp_cnt[0]));
      chk("empty_lo", 32'(empty_lo), 32'(exp_cnt[0] == 4'd0));
      chk("err_lo",   32'(err_lo),   32'(exp_err[0]));
      chk("gnt_hi",   32'(gnt_hi),   32'(exp_gnt[1]));
      chk("idx_hi",   32'(idx_hi),   32'(exp_idx[1]));
      chk("cnt_hi",   32'(cnt_hi),   32'(exp_cnt[1]));
      chk("empty_hi", 32'(empty_hi), 32'(exp_cnt[1] == 4'd0));
      chk("err_hi",   32'(err_hi),   32'(exp_err[1]));
    end
  end

  // Apply one cycle of stimulus; returns at the following negedge with results visible.
  task automatic drive(input logic [1:0] req, input logic [7:0] fm, input logic rn);
    rst_n     = rn;
    alloc_req = req;
    free_mask = fm;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    alloc_req = 2'b00;
    free_mask = 8'h00;
    @(negedge clk);

    // Reset state
    drive(2'b00, 8'h00, 1'b0);
    chk("rst_gnt",   32'(gnt_lo),   32'h0);
    chk("rst_idx",   32'(idx_lo),   32'h0);
    chk("rst_cnt",   32'(cnt_lo),   32'h8);
    chk("rst_empty", 32'(empty_lo), 32'h0);
    chk("rst_err",   32'(err_lo),   32'h0);

    // Two lanes after reset: low-first gives {0,1}, high-first gives {7,6}
    drive(2'b11, 8'h00, 1'b1);
    chk("d030_gnt",    32'(gnt_lo), 32'h3);
    chk("d030_idx",    32'(idx_lo), 32'(6'o10));
    chk("d030_cnt",    32'(cnt_lo), 32'h6);
    chk("d031_gnt_hi", 32'(gnt_hi), 32'h3);
    chk("d031_idx_hi", 32'(idx_hi), 32'(6'o67));

    // Drain the pool, then leave only index 0 free
    drive(2'b11, 8'h00, 1'b1);
    drive(2'b11, 8'h00, 1'b1);
    drive(2'b11, 8'h00, 1'b1);
    chk("drain_cnt",   32'(cnt_lo),   32'h0);
    chk("drain_empty", 32'(empty_lo), 32'h1);
    drive(2'b00, 8'h01, 1'b1);
    chk("free0_cnt", 32'(cnt_lo), 32'h1);

    // Only lane 1 requests: it takes rank 0, index 0
    drive(2'b10, 8'h00, 1'b1);
    chk("d032_gnt",    32'(gnt_lo),   32'h2);
    chk("d032_idx",    32'(idx_lo),   32'h0);
    chk("d032_idx_hi", 32'(idx_hi),   32'h0);
    drive(2'b11, 8'h00, 1'b1);
    chk("d032_nogrant", 32'(gnt_lo),   32'h0);
    chk("d032_empty",   32'(empty_lo), 32'h1);

    // Release and request in the same cycle: no bypass, granted next cycle
    drive(2'b01, 8'h04, 1'b1);
    chk("d033_nobypass", 32'(gnt_lo), 32'h0);
    chk("d033_cnt",      32'(cnt_lo), 32'h1);
    drive(2'b01, 8'h00, 1'b1);
    chk("d033_gnt", 32'(gnt_lo), 32'h1);
    chk("d033_idx", 32'(idx_lo), 32'h2);

    // Double release of index 7
    drive(2'b00, 8'h80, 1'b1);
    chk("d034_first_err", 32'(err_lo), 32'h0);
    chk("d034_first_cnt", 32'(cnt_lo), 32'h1);
    drive(2'b00, 8'h80, 1'b1);
    chk("d034_err",    32'(err_lo), 32'h1);
    chk("d034_err_hi", 32'(err_hi), 32'h1);
    chk("d034_cnt",    32'(cnt_lo), 32'h1);
    drive(2'b00, 8'h00, 1'b1);
    chk("d034_pulse", 32'(err_lo), 32'h0);

    // Only one free index for two requesters
    drive(2'b11, 8'h00, 1'b1);
    chk("one_left_gnt", 32'(gnt_lo), 32'h1);
    chk("one_left_idx", 32'(idx_lo), 32'h7);

    // Reset while requesting discards the grant
    drive(2'b11, 8'h00, 1'b0);
    chk("d035_gnt", 32'(gnt_lo), 32'h0);
    chk("d035_cnt", 32'(cnt_lo), 32'h8);
    chk("d035_idx", 32'(idx_lo), 32'h0);

    // Randomised traffic, checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      drive(2'($urandom),
            ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00,
            ($urandom_range(0, 59) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
